// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Op encodings, shift prefixes and sequencer state type shared by
//            the 1-bit ALU slice and the bit-serial controller.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_PASS  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_ADDNB = 4'b0010;
    localparam logic [3:0] OP_DEC   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;

    localparam logic [1:0] SHR = 2'b10;
    localparam logic [1:0] SHL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : 1-bit ALU slice: full adder with selectable B operand plus
//            bitwise logic functions.
// Revision : 1.0
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [3:0] sel_i,
    output logic       f_o,
    output logic       cout_o
);

    logic w_bop;

    always_comb begin
        w_bop  = 1'b0;
        f_o    = 1'b0;
        cout_o = 1'b0;
        case (sel_i)
            OP_PASS, OP_ADD, OP_ADDNB, OP_DEC: begin
                // Arithmetic ops differ only in the B operand fed to the adder
                case (sel_i[1:0])
                    2'b00:   w_bop = 1'b0;
                    2'b01:   w_bop = b_i;
                    2'b10:   w_bop = ~b_i;
                    default: w_bop = 1'b1;
                endcase
                f_o    = a_i ^ w_bop ^ cin_i;
                cout_o = (a_i & w_bop) | (cin_i & (a_i ^ w_bop));
            end
            OP_AND:  f_o = a_i & b_i;
            OP_OR:   f_o = a_i | b_i;
            OP_XOR:  f_o = a_i ^ b_i;
            OP_NOT:  f_o = ~a_i;
            default: f_o = a_i;
        endcase
    end

endmodule : alu
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_ctrl
// Brief    : Bit-serial sequencer running a WIDTH-bit operation LSB first
//            through one 1-bit ALU slice; shifts complete in a single cycle.
// Revision : 1.0
// ============================================================================
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o
);

    localparam int                c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [3:0]         r_op;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;

    logic w_f;
    logic w_cout;

    alu u_alu (
        .a_i    (r_a_sh[0]),
        .b_i    (r_b_sh[0]),
        .cin_i  (r_carry),
        .sel_i  (r_op),
        .f_o    (w_f),
        .cout_o (w_cout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_op     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_a_sh   <= a_i;
                        r_b_sh   <= b_i;
                        r_op     <= op_i;
                        r_carry  <= cin_i;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (r_op[3]) begin
                        // Operand register is still unshifted here; r_carry holds the shift-in bit
                        if (r_op[3:2] == SHL) begin
                            r_result <= {r_a_sh[WIDTH-2:0], r_carry};
                            r_cout   <= r_a_sh[WIDTH-1];
                        end else begin
                            r_result <= {r_carry, r_a_sh[WIDTH-1:1]};
                            r_cout   <= r_a_sh[0];
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_result <= {w_f, r_result[WIDTH-1:1]};
                        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                        r_carry  <= w_cout;
                        if (r_cnt == c_LAST_BIT) begin
                            // Final carry captured here so it is valid alongside done_o
                            r_cout  <= r_op[2] ? 1'b0 : w_cout;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;
    assign cout_o   = r_cout;

endmodule : alu_serial_ctrl
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_ctrl
// Brief    : Directed self-checking bench for alu_serial_ctrl at WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op    = 4'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [W-1:0] mdl_res  = '0;
    logic         mdl_cout = 1'b0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .cin_i    (cin),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .cout_o   (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word-level reference: returns {cout, result}
    function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic c);
        logic [W:0] s;
        logic [W:0] cw;
        cw = {{W{1'b0}}, c};
        if (o[3]) begin
            if (o[2]) s = {x[W-1], x[W-2:0], c};
            else      s = {x[0], c, x[W-1:1]};
        end else begin
            case (o[2:0])
                3'd0:    s = {1'b0, x} + cw;
                3'd1:    s = {1'b0, x} + {1'b0, y} + cw;
                3'd2:    s = {1'b0, x} + {1'b0, ~y} + cw;
                3'd3:    s = {1'b0, x} + {1'b0, {W{1'b1}}} + cw;
                3'd4:    s = {1'b0, x & y};
                3'd5:    s = {1'b0, x | y};
                3'd6:    s = {1'b0, x ^ y};
                default: s = {1'b0, ~x};
            endcase
        end
        return s;
    endfunction

    // Every cycle outside RUN the outputs must match the model's latest answer
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check("done_result", result, mdl_res);
                check("done_cout", cout, mdl_cout);
            end else if (!busy) begin
                check("hold_result", result, mdl_res);
                check("hold_cout", cout, mdl_cout);
            end
        end
    end

    task automatic run_op(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic c, input logic [W-1:0] er,
                          input logic ec, input int lat, input bit hold);
        int k;
        int busy_n;
        logic [W:0] m;
        @(negedge clk);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        m = model(o, x, y, c);
        mdl_res  = m[W-1:0];
        mdl_cout = m[W];
        check($sformatf("%s_model_res", nm), m[W-1:0], er);
        check($sformatf("%s_model_cout", nm), m[W], ec);
        if (!hold) start = 1'b0;
        a = ~x; b = ~y; cin = ~c;
        check($sformatf("%s_busy_rise", nm), busy, 1'b1);
        k = 0;
        busy_n = 0;
        while (k < 40) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_n++;
            k++;
        end
        start = 1'b0;
        check($sformatf("%s_latency", nm), k, lat);
        check($sformatf("%s_busy_cycles", nm), busy_n, lat);
        check($sformatf("%s_result", nm), result, er);
        check($sformatf("%s_cout", nm), cout, ec);
        check($sformatf("%s_busy_in_done", nm), busy, 1'b0);
        @(negedge clk);
        check($sformatf("%s_done_pulse", nm), done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        check("rst_cout", cout, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add",     OP_ADD,   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8, 1'b0);
        run_op("add_ovf", OP_ADD,   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8, 1'b0);
        run_op("pass",    OP_PASS,  8'hFF, 8'h55, 1'b1, 8'h00, 1'b1, 8, 1'b0);
        run_op("sub",     OP_ADDNB, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 8, 1'b0);
        run_op("dec0",    OP_DEC,   8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 8, 1'b0);
        run_op("dec1",    OP_DEC,   8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 8, 1'b0);
        run_op("xor",     OP_XOR,   8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0, 8, 1'b0);
        run_op("not",     OP_NOT,   8'h3C, 8'h00, 1'b0, 8'hC3, 1'b0, 8, 1'b0);
        run_op("and",     OP_AND,   8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 8, 1'b0);
        run_op("or",      OP_OR,    8'h50, 8'h05, 1'b1, 8'h55, 1'b0, 8, 1'b0);
        run_op("shl",     {SHL, 2'b00}, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1, 1'b0);
        run_op("shr",     {SHR, 2'b01}, 8'h81, 8'h00, 1'b1, 8'hC0, 1'b1, 1, 1'b0);

        // start held through RUN must not launch a second operation
        run_op("hold",    OP_ADD,   8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_no_restart", busy, 1'b0);
        end

        // Abort mid-RUN
        @(negedge clk);
        op = OP_ADD; a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mdl_res = '0;
        mdl_cout = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, '0);
        check("abort_cout", cout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt, n);

        run_op("after_abort", OP_ADD, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_serial_ctrl
`default_nettype wire

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer that runs a WIDTH-bit ALU operation through a single instance of the 1-bit `alu` slice, one bit per clock, LSB first. It chains the slice carry through a register and assembles the result word. Shifts bypass the slice and finish in one cycle. It is the control layer between the 1-bit slice and the 32-bit ALU datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width; legal range 2 to 64.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  4  operation, same encoding as the `alu` slice `sel_i`.
- cin_i  in  1  carry-in for arithmetic ops; shift-in bit for shifts.
- a_i  in  WIDTH  operand A, sampled with start_i.
- b_i  in  WIDTH  operand B, sampled with start_i.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse in DONE.
- result_o  out  WIDTH  result; held from DONE until the next accepted start.
- cout_o  out  1  final carry (arithmetic), shifted-out bit (shifts), 0 (logic); held like result_o.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start_i=1:
  - latch a_i and b_i into shift registers, op_i into op_q;
  - load carry_q from cin_i; clear bit counter; go to RUN.
  - Clear result_o and cout_o at the same edge.
- RUN, op_q[3]=0 (ops 0000–0111), each cycle:
  - drive the slice with a_sh[0], b_sh[0], carry_q and op_q;
  - shift slice f_o into result MSB; result shifts right;
  - shift a_sh and b_sh right;
  - carry_q <= slice cout_o;
  - increment counter.
  - After bit WIDTH-1, go to DONE.
- RUN, op_q[3]=1, single cycle, then DONE:
  - 10xx (shr): result = {cin_q, a[WIDTH-1:1]}, cout = a[0].
  - 11xx (shl): result = {a[WIDTH-2:0], cin_q}, cout = a[WIDTH-1].
- Op semantics (arithmetic, ops 0000–0011):
  - 0000: A+cin.
  - 0001: A+B+cin.
  - 0010: A+~B+cin.
  - 0011: A+all-ones+cin, i.e. A-1+cin.
  - cout_o = carry_q after the last bit.
- Op semantics (logic, ops 0100–0111): AND, OR, XOR, NOT A. cout_o = 0 regardless of the slice carry.
- DONE: assert done_o; update cout_o; go to IDLE next cycle.
- start_i outside IDLE is ignored. It is not queued.
- op_i, a_i, b_i and cin_i are don't-care except at the accepting edge.

## Timing
- Reset values: state IDLE, busy_o 0, done_o 0, result_o 0, cout_o 0, counter 0, carry_q 0.
- rst_i asserted mid-RUN aborts immediately. The partial result is discarded and no done_o pulse is produced.
- Arithmetic/logic latency:
  - start accepted at edge E0;
  - busy_o high from E0 to E_WIDTH;
  - done_o high for the cycle after edge E_WIDTH;
  - earliest next start is accepted at E_WIDTH+2.
- Shift latency: busy_o high E0–E1; done_o high after E1.
- Throughput: one op per WIDTH+2 cycles (arithmetic/logic), 3 cycles (shift).
- Counter width is $clog2(WIDTH). The RUN-to-DONE transition occurs when the counter equals WIDTH-1. The counter must not wrap.
- result_o and cout_o are registered and stable outside RUN.

## Structure
- Shared package alu_pkg:
  - op encodings OP_PASS 0000, OP_ADD 0001, OP_ADDNB 0010, OP_DEC 0011, OP_AND 0100, OP_OR 0101, OP_XOR 0110, OP_NOT 0111;
  - shift prefixes SHR 2'b10, SHL 2'b11;
  - state enum {IDLE, RUN, DONE}.
- One sub-module: the existing 1-bit `alu` slice, instantiated once as u_alu. Its inputs are driven only from registered state.
- Shift ops are implemented in this block, not in the slice.

## Test plan
Bench uses WIDTH=8.
- ADD: a=7F, b=01, cin=0 -> result 80, cout 0. done_o exactly 8 edges after the start edge; busy_o high 8 cycles.
- ADD overflow: a=FF, b=01, cin=0 -> result 00, cout 1. Also OP_PASS with a=FF, cin=1 -> 00, cout 1.
- Subtract via 0010: a=05, b=07, cin=1 -> FE, cout 0. Decrement via 0011: a=00, cin=0 -> FF, cout 0. a=01, cin=0 -> 00, cout 1.
- Logic: XOR a=A5, b=0F -> AA, cout 0. NOT a=3C -> C3, cout 0. AND with cin=1 -> cout still 0.
- Shifts:
  - SHL a=81, cin=0 -> 02, cout 1.
  - SHR a=81, cin=1 -> C0, cout 1.
  - done_o 1 edge after start.
- Control:
  - start held high during RUN -> no second op; result unchanged.
  - rst_i pulsed after 3 RUN cycles -> all outputs 0, no done_o.
  - A following start completes with the correct result.
